// File: rtl/bit_16_pkg.sv
// Shared constants and types for the bit_16 ripple-carry adder.
package bit_16_pkg;

  // Operand and sum width of the adder.
  localparam int WIDTH = 16;

  // Full result: carry-out in the top bit, sum below it.
  typedef logic [WIDTH:0] result_t;

  // Two's-complement overflow from the carries around the most significant bit.
  function automatic logic overflow_flag(input logic carry_into_msb, input logic carry_out_msb);
    return carry_into_msb ^ carry_out_msb;
  endfunction

endpackage

// File: rtl/bit_16_full_adder.sv
// One-bit full adder cell used as the building block of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic prop;

  // Propagate term is shared between the sum and the carry logic.
  assign prop = a ^ b;
  assign s    = prop ^ cin;
  assign cout = (a & b) | (cin & prop);

endmodule

// File: rtl/bit_16.sv
// bit_16: ripple-carry adder with combinational sum/cout and a registered
// copy of sum, cout and the signed overflow flag.
module bit_16
  import bit_16_pkg::*;
#(
  parameter int WIDTH_P = bit_16_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH_P-1:0] a,
  input  logic [WIDTH_P-1:0] b,
  input  logic               cin,
  output logic [WIDTH_P-1:0] sum,
  output logic               cout,
  output logic [WIDTH_P-1:0] sum_q,
  output logic               cout_q,
  output logic               ovf_q
);

  // carry[i] is the carry into bit i; carry[WIDTH_P] leaves the top bit.
  logic [WIDTH_P:0]   carry;
  logic [WIDTH_P-1:0] sum_d;
  logic               cout_d;
  logic               ovf_d;

  assign carry[0] = cin;

  // One full adder per bit, chained through the carry vector.
  for (genvar i = 0; i < WIDTH_P; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum_d[i]),
      .cout (carry[i+1])
    );
  end

  assign cout_d = carry[WIDTH_P];
  assign ovf_d  = overflow_flag(carry[WIDTH_P-1], carry[WIDTH_P]);

  // Combinational outputs are independent of clock and reset.
  assign sum  = sum_d;
  assign cout = cout_d;

  // Registered copy of the result; reset clears it immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= {WIDTH_P{1'b0}};
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_bit_16.sv
// Scoreboard bench for bit_16: stimulus pushes expected results, a monitor
// checks combinational and registered outputs one step after each clock edge.
module tb_bit_16;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
  logic [15:0] sum_q;
  logic        cout_q;
  logic        ovf_q;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   stim_done = 1'b0;

  bit_16 dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .sum_q  (sum_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Independent reference: 17-bit add, overflow from operand/result signs.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] r;
    exp_t e;
    r = {1'b0, x} + {1'b0, y} + {16'h0000, c};
    e.sum  = r[15:0];
    e.cout = r[16];
    e.ovf  = (x[15] == y[15]) && (r[15] != x[15]);
    return e;
  endfunction

  task automatic apply(input logic [15:0] x, input logic [15:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; cin = c;
    exp_q.push_back(model(x, y, c));
  endtask

  task automatic apply_hand(input logic [15:0] x, input logic [15:0] y, input logic c,
                            input logic [15:0] es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    a = x; b = y; cin = c;
    e.sum = es; e.cout = ec; e.ovf = eo;
    exp_q.push_back(e);
  endtask

  // Monitor: after each edge, compare the oldest expectation with the outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sum",    {16'h0000, sum},    {16'h0000, e.sum});
        check("cout",   {31'h0, cout},      {31'h0, e.cout});
        check("sum_q",  {16'h0000, sum_q},  {16'h0000, e.sum});
        check("cout_q", {31'h0, cout_q},    {31'h0, e.cout});
        check("ovf_q",  {31'h0, ovf_q},     {31'h0, e.ovf});
      end
    end
  end

  // Stimulus.
  initial begin
    int budget;
    rst = 1'b1; a = 16'd3; b = 16'd5; cin = 1'b0;
    #1;
    check("reset_sum_q",  {16'h0000, sum_q}, 32'h0);
    check("reset_cout_q", {31'h0, cout_q},   32'h0);
    check("reset_ovf_q",  {31'h0, ovf_q},    32'h0);
    check("reset_comb_sum", {16'h0000, sum}, 32'd8);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-computed results.
    apply_hand(16'd3,    16'd5,    1'b0, 16'd8,    1'b0, 1'b0);
    apply_hand(16'hFFFF, 16'd1,    1'b0, 16'h0000, 1'b1, 1'b0);
    apply_hand(16'h7FFF, 16'd1,    1'b0, 16'h8000, 1'b0, 1'b1);
    apply_hand(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    apply_hand(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    apply_hand(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    apply_hand(16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0);
    apply_hand(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Reset mid-run with sum_q holding 8.
    apply_hand(16'd3, 16'd5, 1'b0, 16'd8, 1'b0, 1'b0);
    apply_hand(16'h7FFF, 16'd1, 1'b0, 16'h8000, 1'b0, 1'b1);
    apply_hand(16'd3, 16'd5, 1'b0, 16'd8, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_sum_q",  {16'h0000, sum_q}, 32'h0);
    check("midrst_cout_q", {31'h0, cout_q},   32'h0);
    check("midrst_ovf_q",  {31'h0, ovf_q},    32'h0);
    check("midrst_sum",    {16'h0000, sum},   32'd8);
    rst = 1'b0;
    begin
      exp_t e;
      e.sum = 16'd8; e.cout = 1'b0; e.ovf = 1'b0;
      exp_q.push_back(e);
    end

    // Random sweep against the 17-bit reference.
    for (int i = 0; i < 10000; i++) begin
      apply(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("drain_queue", exp_q.size(), 32'h0);
    stim_done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    if (!stim_done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
    end
  end

endmodule

// File: doc/bit_16.md
BIT_16 -- requirements
Module: bit_16

Interface
REQ-001 Parameter: WIDTH, default 16, operand and sum width; the block SHALL be verified at 16 only.
REQ-002 Port: clk  input  1  rising-edge clock for the registered result copy.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high; it clears all registered outputs.
REQ-004 Port: a  input  16  addend A, unsigned.
REQ-005 Port: b  input  16  addend B, unsigned.
REQ-006 Port: cin  input  1  carry-in to bit 0.
REQ-007 Port: sum  output  16  combinational sum, (a + b + cin) mod 2^16.
REQ-008 Port: cout  output  1  combinational carry-out of bit 15.
REQ-009 Port: sum_q  output  16  sum registered on the clk rising edge.
REQ-010 Port: cout_q  output  1  cout registered on the clk rising edge.
REQ-011 Port: ovf_q  output  1  registered two's-complement overflow flag.

Function
REQ-012 {cout, sum} SHALL equal a + b + cin as a 17-bit unsigned value for every input combination.
REQ-013 sum and cout SHALL be purely combinational, with zero-cycle latency and no dependence on clk or rst; they SHALL settle within one simulation time unit of any input change.
REQ-014 The adder SHALL be a ripple-carry chain: carry into bit 0 is cin, carry into bit i+1 is the carry-out of bit i, and cout is the carry-out of bit 15.
REQ-015 Each bit SHALL compute s = a_i XOR b_i XOR c_i and c_(i+1) = (a_i AND b_i) OR (c_i AND (a_i XOR b_i)).
REQ-016 Overflow SHALL be defined as the carry into bit 15 XOR the carry out of bit 15.
REQ-017 On every clk rising edge with rst low, sum_q, cout_q and ovf_q SHALL load the current sum, cout and overflow; registered latency is one cycle.
REQ-018 There is no handshake and no enable: a new operand pair is accepted every cycle.
REQ-019 Wrap-around: a result of 2^16 or more SHALL wrap modulo 2^16 in sum, with cout = 1.
REQ-020 If an input changes in the same cycle as a clock edge, the registers SHALL capture the value settled before that edge.

Reset
REQ-021 While rst is high, sum_q, cout_q and ovf_q SHALL be 0 immediately, independent of clk.
REQ-022 Reset SHALL NOT affect sum or cout.
REQ-023 Registered outputs SHALL resume tracking the inputs on the first rising clk edge after rst deasserts.
REQ-024 Reset asserted mid-operation SHALL discard the registered value with no partial update.

Structure
REQ-025 A shared package SHALL hold the WIDTH constant (16) and the 17-bit result typedef.
REQ-026 A one-bit sub-module, full_adder (inputs a, b, cin; outputs s, cout), SHALL be instantiated WIDTH times through a generate loop.
REQ-027 The three output registers SHALL sit in a single always block in bit_16.

Verification
REQ-028 Basic add: a=3, b=5, cin=0 -> sum=8, cout=0 after #1; sum_q=8 after the next clk edge.
REQ-029 Wrap: a=16'hFFFF, b=1, cin=0 -> sum=0, cout=1, ovf_q=0 after the edge.
REQ-030 Signed overflow: a=16'h7FFF, b=1, cin=0 -> sum=16'h8000, cout=0, ovf_q=1.
REQ-031 Carry-in: a=0, b=0, cin=1 -> sum=1; and a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
REQ-032 Reset mid-run: assert rst between edges with sum_q=8 -> sum_q, cout_q and ovf_q=0 at once while sum stays 8; deassert -> sum_q=8 on the next edge.
REQ-033 Random sweep: 10000 random a, b, cin -> {cout, sum} matches the 17-bit reference sum every time.
